// File: rtl/usb1bd_pa_pkg.sv
// Shared definitions for the USB1.1 packet assembler: FSM encoding, PID codes
// and the byte-building helpers used on the UTMI transmit path.
package usb1bd_pa_pkg;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_TOKEN = 6'b000010,
        ST_PID   = 6'b000100,
        ST_DATA  = 6'b001000,
        ST_CRC1  = 6'b010000,
        ST_CRC2  = 6'b100000
    } pa_state_e;

    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_NYET  = 4'h6;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_DATA2 = 4'h7;
    localparam logic [3:0] PID_MDATA = 4'hF;

    function automatic logic [3:0] token_pid(input logic [1:0] sel);
        case (sel)
            2'd0:    return PID_ACK;
            2'd1:    return PID_NAK;
            2'd2:    return PID_STALL;
            default: return PID_NYET;
        endcase
    endfunction

    function automatic logic [3:0] data_pid(input logic [1:0] sel);
        case (sel)
            2'd0:    return PID_DATA0;
            2'd1:    return PID_DATA1;
            2'd2:    return PID_DATA2;
            default: return PID_MDATA;
        endcase
    endfunction

    // The PID byte carries its own check nibble in the upper half.
    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // The residue goes out inverted with its most significant bit first on the
    // wire; since UTMI bytes are shifted LSB first, the upper register byte is
    // bit-reversed and sent first, the lower byte second.
    function automatic logic [7:0] crc_tx_byte(input logic [15:0] crc, input logic second);
        return second ? ~bitrev8(crc[7:0]) : ~bitrev8(crc[15:8]);
    endfunction

endpackage

// File: rtl/usb1bd_pa_mc_if.sv
// UTMI transmit byte stream plus the per-endpoint show-ahead FIFO read port.
interface usb1bd_pa_mc_if #(
    parameter int NUM_EP = 4
);
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_valid_last;
    logic                tx_first;
    logic                tx_ready;
    logic [NUM_EP*8-1:0] tx_fifo_data;
    logic [NUM_EP-1:0]   tx_fifo_empty;
    logic [NUM_EP-1:0]   tx_fifo_re;

    modport master (
        output tx_data, tx_valid, tx_valid_last, tx_first, tx_fifo_re,
        input  tx_ready, tx_fifo_data, tx_fifo_empty
    );

    modport slave (
        input  tx_data, tx_valid, tx_valid_last, tx_first, tx_fifo_re,
        output tx_ready, tx_fifo_data, tx_fifo_empty
    );
endinterface

// File: rtl/usb1bd_crc16.sv
// Byte-wide CRC16 (x^16+x^15+x^2+1) step; din[7] is shifted in first, so the
// caller presents each byte bit-reversed to get USB LSB-first ordering.
module usb1bd_crc16 (
    input  logic [15:0] crc_in,
    input  logic [7:0]  din,
    output logic [15:0] crc_out
);
    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ din[i]) ? 16'h8005 : 16'h0000);
        end
        crc_out = c;
    end
endmodule

// File: rtl/usb1bd_pa_mc.sv
// Multi-endpoint USB1.1 packet assembler: emits handshakes and data packets
// (PID, payload from a selected TX FIFO, CRC16) on the UTMI byte interface.
module usb1bd_pa_mc
    import usb1bd_pa_pkg::*;
#(
    parameter  int NUM_EP = 4,
    parameter  int MPW    = 10,
    localparam int EPW    = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    usb1bd_pa_mc_if.master   bus,
    input  logic             cfg_tx_send_token,
    input  logic [1:0]       cfg_tx_token_pid_sel,
    input  logic             cfg_tx_send_data,
    input  logic [1:0]       cfg_tx_data_pid_sel,
    input  logic [EPW-1:0]   cfg_tx_ep_sel,
    input  logic [MPW-1:0]   cfg_max_pkt,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [MPW-1:0]   tx_byte_cnt,
    output logic [5:0]       state
);

    pa_state_e          state_q, state_d;
    logic [3:0]         pid_q;
    logic [EPW-1:0]     ep_q;
    logic [MPW-1:0]     max_q;
    logic               ep_ok_q;
    logic [15:0]        crc_q, crc_next;
    logic [MPW-1:0]     cnt_q;
    logic               done_q;

    logic [7:0]         head;
    logic               head_empty;
    logic               accept_tok, accept_dat;
    logic               byte_acc, done_d;
    logic [7:0]         data_c;
    logic               valid_c, first_c, last_c;
    logic [NUM_EP-1:0]  re_c;

    assign accept_tok = (state_q == ST_IDLE) && cfg_tx_send_token;
    assign accept_dat = (state_q == ST_IDLE) && cfg_tx_send_data && !cfg_tx_send_token;

    always_comb begin
        head       = 8'h00;
        head_empty = 1'b1;
        for (int i = 0; i < NUM_EP; i++) begin
            if (ep_q == EPW'(i)) begin
                head       = bus.tx_fifo_data[8*i +: 8];
                head_empty = bus.tx_fifo_empty[i];
            end
        end
    end

    // Request parameters are frozen for the whole packet.
    always_ff @(posedge clk) begin
        if (accept_tok) begin
            pid_q <= token_pid(cfg_tx_token_pid_sel);
        end else if (accept_dat) begin
            pid_q   <= data_pid(cfg_tx_data_pid_sel);
            ep_q    <= cfg_tx_ep_sel;
            max_q   <= cfg_max_pkt;
            ep_ok_q <= (int'(cfg_tx_ep_sel) < NUM_EP);
        end
    end

    usb1bd_crc16 u_crc16 (
        .crc_in  (crc_q),
        .din     (bitrev8(head)),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d  = state_q;
        data_c   = 8'h00;
        valid_c  = 1'b0;
        first_c  = 1'b0;
        last_c   = 1'b0;
        re_c     = '0;
        byte_acc = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_tx_send_token)     state_d = ST_TOKEN;
                else if (cfg_tx_send_data) state_d = ST_PID;
            end
            ST_TOKEN: begin
                data_c  = pid_byte(pid_q);
                valid_c = 1'b1;
                first_c = 1'b1;
                last_c  = 1'b1;
                if (bus.tx_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_PID: begin
                data_c  = pid_byte(pid_q);
                valid_c = 1'b1;
                first_c = 1'b1;
                if (bus.tx_ready) begin
                    state_d = (ep_ok_q && !head_empty && (max_q != '0)) ? ST_DATA : ST_CRC1;
                end
            end
            ST_DATA: begin
                data_c = head;
                // An empty FIFO here means the payload ran out: close the packet.
                if (head_empty) begin
                    state_d = ST_CRC1;
                end else begin
                    valid_c = 1'b1;
                    if (bus.tx_ready) begin
                        byte_acc = 1'b1;
                        re_c     = NUM_EP'(1) << ep_q;
                        if (cnt_q + MPW'(1) == max_q) state_d = ST_CRC1;
                    end
                end
            end
            ST_CRC1: begin
                data_c  = crc_tx_byte(crc_q, 1'b0);
                valid_c = 1'b1;
                if (bus.tx_ready) state_d = ST_CRC2;
            end
            ST_CRC2: begin
                data_c  = crc_tx_byte(crc_q, 1'b1);
                valid_c = 1'b1;
                last_c  = 1'b1;
                if (bus.tx_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            crc_q   <= 16'hFFFF;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept_dat) begin
                crc_q <= 16'hFFFF;
                cnt_q <= '0;
            end else if (byte_acc) begin
                crc_q <= crc_next;
                cnt_q <= cnt_q + MPW'(1);
            end
        end
    end

    assign bus.tx_data       = data_c;
    assign bus.tx_valid      = valid_c;
    assign bus.tx_first      = first_c;
    assign bus.tx_valid_last = last_c;
    assign bus.tx_fifo_re    = re_c;
    assign tx_busy           = (state_q != ST_IDLE);
    assign tx_done           = done_q;
    assign tx_byte_cnt       = cnt_q;
    assign state             = state_q;

endmodule

// File: tb/tb_usb1bd_pa_mc.sv
// Directed bench for usb1bd_pa_mc: per-endpoint FIFO models, a UTMI byte
// capture on the falling edge, and one task per scenario.
module tb_usb1bd_pa_mc;
    localparam int NUM_EP = 4;
    localparam int MPW    = 10;
    localparam int EPW    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    usb1bd_pa_mc_if #(.NUM_EP(NUM_EP)) bus ();

    logic           cfg_tx_send_token = 1'b0;
    logic [1:0]     cfg_tx_token_pid_sel = 2'd0;
    logic           cfg_tx_send_data = 1'b0;
    logic [1:0]     cfg_tx_data_pid_sel = 2'd0;
    logic [EPW-1:0] cfg_tx_ep_sel = '0;
    logic [MPW-1:0] cfg_max_pkt = '0;
    logic           tx_busy, tx_done;
    logic [MPW-1:0] tx_byte_cnt;
    logic [5:0]     state;

    usb1bd_pa_mc #(.NUM_EP(NUM_EP), .MPW(MPW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .bus                  (bus),
        .cfg_tx_send_token    (cfg_tx_send_token),
        .cfg_tx_token_pid_sel (cfg_tx_token_pid_sel),
        .cfg_tx_send_data     (cfg_tx_send_data),
        .cfg_tx_data_pid_sel  (cfg_tx_data_pid_sel),
        .cfg_tx_ep_sel        (cfg_tx_ep_sel),
        .cfg_max_pkt          (cfg_max_pkt),
        .tx_busy              (tx_busy),
        .tx_done              (tx_done),
        .tx_byte_cnt          (tx_byte_cnt),
        .state                (state)
    );

    // FIFO models: rd advances only on pops, wr only when the bench loads bytes.
    logic [7:0]        mem [NUM_EP][64];
    int                rd [NUM_EP];
    int                wr [NUM_EP];
    logic [NUM_EP-1:0] pend = '0;
    int                bad_pop = 0;
    int                done_cnt = 0;
    logic [7:0]        cap_data [$];
    logic              cap_first [$];
    logic              cap_last [$];
    bit                throttle = 1'b0;
    int                checks = 0;
    int                errors = 0;

    always_comb begin
        bus.tx_fifo_data  = '0;
        bus.tx_fifo_empty = '1;
        for (int i = 0; i < NUM_EP; i++) begin
            bus.tx_fifo_data[8*i +: 8] = mem[i][rd[i] % 64];
            bus.tx_fifo_empty[i]       = (rd[i] == wr[i]);
        end
    end

    always @(negedge clk) begin
        pend <= bus.tx_fifo_re;
        if (bus.tx_valid && bus.tx_ready) begin
            cap_data.push_back(bus.tx_data);
            cap_first.push_back(bus.tx_first);
            cap_last.push_back(bus.tx_valid_last);
        end
        if (tx_done) done_cnt++;
        if ($countones(bus.tx_fifo_re) > 1) bad_pop++;
        for (int i = 0; i < NUM_EP; i++)
            if (bus.tx_fifo_re[i] && bus.tx_fifo_empty[i]) bad_pop++;
    end

    always @(posedge clk) begin
        for (int i = 0; i < NUM_EP; i++)
            if (pend[i]) rd[i] <= rd[i] + 1;
    end

    always @(posedge clk) begin
        #1;
        bus.tx_ready = throttle ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ep, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) mem[ep][(wr[ep] + k) % 64] = base + 8'(k);
        wr[ep] = wr[ep] + n;
    endtask

    task automatic send_token(input logic [1:0] sel);
        tick();
        cfg_tx_token_pid_sel = sel;
        cfg_tx_send_token    = 1'b1;
        tick();
        cfg_tx_send_token    = 1'b0;
    endtask

    task automatic send_data(input logic [1:0] pid, input logic [EPW-1:0] ep, input logic [MPW-1:0] mx);
        tick();
        cfg_tx_data_pid_sel = pid;
        cfg_tx_ep_sel       = ep;
        cfg_max_pkt         = mx;
        cfg_tx_send_data    = 1'b1;
        tick();
        cfg_tx_send_data    = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int d0, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done_cnt > d0) break;
            tick();
        end
        if (done_cnt > d0) ok = 1'b1;
    endtask

    function automatic logic [15:0] usb_crc(input logic [7:0] d [$]);
        logic [15:0] c = 16'hFFFF;
        foreach (d[k]) begin
            c = c ^ {8'h00, d[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (state !== 6'b000001) begin errors++; $display("FAIL reset_state got %b want 000001", state); end
        checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.tx_valid); end
        checks++; if (bus.tx_first !== 1'b0 || bus.tx_valid_last !== 1'b0) begin errors++; $display("FAIL reset_first_last got %b%b want 00", bus.tx_first, bus.tx_valid_last); end
        checks++; if (bus.tx_fifo_re !== 4'b0000) begin errors++; $display("FAIL reset_re got %b want 0000", bus.tx_fifo_re); end
        checks++; if (tx_busy !== 1'b0 || tx_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", tx_busy, tx_done); end
        checks++; if (tx_byte_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", tx_byte_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_data9();
        int s = cap_data.size(); int d0 = done_cnt; int r2 = rd[2]; bit ok;
        logic [7:0] exp [$];
        exp.push_back(8'h4B);
        for (int k = 0; k < 9; k++) exp.push_back(8'h31 + 8'(k));
        exp.push_back(8'hC8); exp.push_back(8'hB4);
        load(2, 9, 8'h31);
        send_data(2'd1, 2'd2, 10'd64);
        cfg_tx_ep_sel = 2'd1; cfg_max_pkt = 10'd1; cfg_tx_data_pid_sel = 2'd0;
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL data9_busy got %b want 1", tx_busy); end
        wait_done(200, d0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL data9_timeout no tx_done within budget"); end
        checks++; if (cap_data.size() - s != 12) begin errors++; $display("FAIL data9_len got %0d want 12", cap_data.size() - s); end
        for (int k = 0; k < 12 && s + k < cap_data.size(); k++) begin
            checks++;
            if (cap_data[s+k] !== exp[k] || cap_first[s+k] !== (k == 0) || cap_last[s+k] !== (k == 11)) begin
                errors++;
                $display("FAIL data9_byte%0d got %h f%b l%b want %h f%b l%b", k, cap_data[s+k], cap_first[s+k], cap_last[s+k], exp[k], k == 0, k == 11);
            end
        end
        checks++; if (tx_byte_cnt !== 10'd9) begin errors++; $display("FAIL data9_cnt got %0d want 9", tx_byte_cnt); end
        checks++; if (rd[2] - r2 != 9 || rd[0] != wr[0] || rd[1] != wr[1] || bad_pop != 0) begin errors++; $display("FAIL data9_pops got ep2=%0d bad=%0d want 9 0", rd[2] - r2, bad_pop); end
    endtask

    task automatic test_token();
        int s = cap_data.size(); int d0 = done_cnt; bit ok;
        send_token(2'd2);
        wait_done(50, d0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL token_timeout no tx_done within budget"); end
        checks++; if (cap_data.size() - s != 1) begin errors++; $display("FAIL token_len got %0d want 1", cap_data.size() - s); end
        if (cap_data.size() > s) begin
            checks++;
            if (cap_data[s] !== 8'h1E || cap_first[s] !== 1'b1 || cap_last[s] !== 1'b1) begin
                errors++; $display("FAIL token_byte got %h f%b l%b want 1e f1 l1", cap_data[s], cap_first[s], cap_last[s]);
            end
        end
        checks++; if (tx_byte_cnt !== 10'd9) begin errors++; $display("FAIL token_cnt got %0d want 9", tx_byte_cnt); end
        tick();
        checks++; if (tx_busy !== 1'b0 || tx_done !== 1'b0) begin errors++; $display("FAIL token_idle got busy=%b done=%b want 0 0", tx_busy, tx_done); end
    endtask

    task automatic test_zero_len();
        int s = cap_data.size(); int d0 = done_cnt; int p0 = bad_pop; int r0 = rd[0]; bit ok;
        send_data(2'd0, 2'd0, 10'd64);
        wait_done(50, d0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL zlp_timeout no tx_done within budget"); end
        checks++;
        if (cap_data.size() - s != 3) begin
            errors++; $display("FAIL zlp_len got %0d want 3", cap_data.size() - s);
        end else if (cap_data[s] !== 8'hC3 || cap_data[s+1] !== 8'h00 || cap_data[s+2] !== 8'h00) begin
            errors++; $display("FAIL zlp_bytes got %h %h %h want c3 00 00", cap_data[s], cap_data[s+1], cap_data[s+2]);
        end
        checks++; if (rd[0] != r0 || bad_pop != p0) begin errors++; $display("FAIL zlp_pops got %0d bad=%0d want 0 0", rd[0] - r0, bad_pop - p0); end
        checks++; if (tx_byte_cnt !== '0) begin errors++; $display("FAIL zlp_cnt got %0d want 0", tx_byte_cnt); end
    endtask

    task automatic test_max_cut();
        int s = cap_data.size(); int d0 = done_cnt; bit ok;
        logic [7:0] pay [$]; logic [15:0] crc;
        for (int k = 0; k < 8; k++) pay.push_back(8'h40 + 8'(k));
        crc = usb_crc(pay);
        load(1, 20, 8'h40);
        send_data(2'd0, 2'd1, 10'd8);
        wait_done(200, d0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cut_timeout no tx_done within budget"); end
        checks++; if (cap_data.size() - s != 11) begin errors++; $display("FAIL cut_len got %0d want 11", cap_data.size() - s); end
        if (cap_data.size() - s == 11) begin
            checks++; if (cap_data[s] !== 8'hC3) begin errors++; $display("FAIL cut_pid got %h want c3", cap_data[s]); end
            for (int k = 0; k < 8; k++) begin
                checks++; if (cap_data[s+1+k] !== pay[k]) begin errors++; $display("FAIL cut_byte%0d got %h want %h", k, cap_data[s+1+k], pay[k]); end
            end
            checks++; if ({cap_data[s+10], cap_data[s+9]} !== crc) begin errors++; $display("FAIL cut_crc got %h%h want %h", cap_data[s+10], cap_data[s+9], crc); end
        end
        checks++; if (wr[1] - rd[1] != 12) begin errors++; $display("FAIL cut_remain got %0d want 12", wr[1] - rd[1]); end
        checks++; if (tx_byte_cnt !== 10'd8) begin errors++; $display("FAIL cut_cnt got %0d want 8", tx_byte_cnt); end
        rd_drain_note: begin end
    endtask

    task automatic test_throttle();
        int s = cap_data.size(); int d0 = done_cnt; int r2 = rd[2]; int p0 = bad_pop; bit ok;
        logic [7:0] exp [$];
        exp.push_back(8'h4B);
        for (int k = 0; k < 9; k++) exp.push_back(8'h31 + 8'(k));
        exp.push_back(8'hC8); exp.push_back(8'hB4);
        load(2, 9, 8'h31);
        throttle = 1'b1;
        send_data(2'd1, 2'd2, 10'd64);
        wait_done(600, d0, ok);
        throttle = 1'b0;
        tick();
        checks++; if (!ok) begin errors++; $display("FAIL thr_timeout no tx_done within budget"); end
        checks++; if (cap_data.size() - s != 12) begin errors++; $display("FAIL thr_len got %0d want 12", cap_data.size() - s); end
        for (int k = 0; k < 12 && s + k < cap_data.size(); k++) begin
            checks++; if (cap_data[s+k] !== exp[k]) begin errors++; $display("FAIL thr_byte%0d got %h want %h", k, cap_data[s+k], exp[k]); end
        end
        checks++; if (rd[2] - r2 != 9 || bad_pop != p0) begin errors++; $display("FAIL thr_pops got %0d bad=%0d want 9 0", rd[2] - r2, bad_pop - p0); end
        checks++; if (tx_byte_cnt !== 10'd9) begin errors++; $display("FAIL thr_cnt got %0d want 9", tx_byte_cnt); end
    endtask

    task automatic test_simultaneous();
        int s = cap_data.size(); int d0 = done_cnt; int r2 = rd[2]; bit ok;
        load(2, 3, 8'h70);
        tick();
        cfg_tx_token_pid_sel = 2'd1; cfg_tx_send_token = 1'b1;
        cfg_tx_data_pid_sel = 2'd0; cfg_tx_ep_sel = 2'd2; cfg_max_pkt = 10'd64; cfg_tx_send_data = 1'b1;
        tick();
        cfg_tx_send_token = 1'b0; cfg_tx_send_data = 1'b0;
        wait_done(50, d0, ok);
        repeat (6) tick();
        checks++; if (!ok) begin errors++; $display("FAIL simul_timeout no tx_done within budget"); end
        checks++;
        if (cap_data.size() - s != 1) begin
            errors++; $display("FAIL simul_len got %0d want 1", cap_data.size() - s);
        end else if (cap_data[s] !== 8'h5A) begin
            errors++; $display("FAIL simul_byte got %h want 5a", cap_data[s]);
        end
        checks++; if (done_cnt - d0 != 1 || tx_busy !== 1'b0 || rd[2] != r2) begin errors++; $display("FAIL simul_extra got done=%0d busy=%b pops=%0d want 1 0 0", done_cnt - d0, tx_busy, rd[2] - r2); end
        checks++; if (tx_byte_cnt !== 10'd9) begin errors++; $display("FAIL simul_cnt got %0d want 9", tx_byte_cnt); end
    endtask

    task automatic test_reset_mid();
        int s = cap_data.size(); int d0 = done_cnt; int r3 = rd[3]; int sent; bit ok;
        load(3, 10, 8'h60);
        send_data(2'd2, 2'd3, 10'd64);
        for (int c = 0; c < 50; c++) begin
            if (cap_data.size() >= s + 3) break;
            tick();
        end
        checks++; if (cap_data.size() < s + 3) begin errors++; $display("FAIL rstmid_start got %0d bytes want >=3", cap_data.size() - s); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0 || tx_busy !== 1'b0 || state !== 6'b000001 || bus.tx_fifo_re !== 4'b0 || tx_byte_cnt !== '0) begin
            errors++; $display("FAIL rstmid_outputs got v=%b busy=%b st=%b re=%b cnt=%0d want 0 0 000001 0000 0", bus.tx_valid, tx_busy, state, bus.tx_fifo_re, tx_byte_cnt);
        end
        repeat (4) tick();
        sent = cap_data.size() - s - 1;
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL rstmid_done got %0d pulses want 0", done_cnt - d0); end
        checks++; if (rd[3] - r3 != sent) begin errors++; $display("FAIL rstmid_pops got %0d want %0d", rd[3] - r3, sent); end
        rst_n = 1'b1;
        tick();
        s = cap_data.size(); d0 = done_cnt;
        send_token(2'd0);
        wait_done(50, d0, ok);
        checks++;
        if (!ok || cap_data.size() - s != 1) begin
            errors++; $display("FAIL rstmid_after got ok=%b len=%0d want 1 1", ok, cap_data.size() - s);
        end else if (cap_data[s] !== 8'hD2) begin
            errors++; $display("FAIL rstmid_after_byte got %h want d2", cap_data[s]);
        end
    endtask

    initial begin
        test_reset();
        test_data9();
        test_token();
        test_zero_len();
        test_max_cut();
        test_throttle();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
